// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_pkg                                                         |
// | Purpose  : Shared VGA types, default 640x480@60 timing, bar colour lookup  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package vga_pkg;

    typedef enum logic [1:0] {PM_BARS, PM_GRID, PM_RAMP, PM_SCROLL} pattern_mode_t;

    localparam int c_RGB_WIDTH  = 10;
    localparam int c_H_DISPLAY  = 640;
    localparam int c_H_FP       = 16;
    localparam int c_H_SYNC     = 96;
    localparam int c_H_BP       = 48;
    localparam int c_V_DISPLAY  = 480;
    localparam int c_V_FP       = 10;
    localparam int c_V_SYNC     = 2;
    localparam int c_V_BP       = 33;
    localparam int c_GRID_SHIFT = 5;

    // Returns {r_on, g_on, b_on} for bars 0..7: white..black
    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing                                                      |
// | Purpose  : Raster counters, sync/visible decode and frame wrap strobes     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = c_H_DISPLAY,
    parameter int H_FP      = c_H_FP,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BP      = c_H_BP,
    parameter int V_DISPLAY = c_V_DISPLAY,
    parameter int V_FP      = c_V_FP,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BP      = c_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP,
    localparam int CW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_visible,
    output logic          o_line_end,
    output logic          o_frame_end,
    output logic          o_frame_origin
);

    logic [CW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [31:0]   w_h;
    logic [31:0]   w_v;
    logic          w_line_end;
    logic          w_last_line;

    assign w_h         = 32'(r_h_cnt);
    assign w_v         = 32'(r_v_cnt);
    assign w_line_end  = (r_h_cnt == CW'(H_TOTAL - 1));
    assign w_last_line = (r_v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_line_end) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_last_line ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CW'(1);
        end
    end

    assign o_h_cnt        = r_h_cnt;
    assign o_v_cnt        = r_v_cnt;
    assign o_hsync        = (w_h >= H_DISPLAY + H_FP && w_h < H_DISPLAY + H_FP + H_SYNC)
                            ? HSYNC_POL : ~HSYNC_POL;
    assign o_vsync        = (w_v >= V_DISPLAY + V_FP && w_v < V_DISPLAY + V_FP + V_SYNC)
                            ? VSYNC_POL : ~VSYNC_POL;
    assign o_visible      = (w_h < H_DISPLAY) && (w_v < V_DISPLAY);
    assign o_line_end     = w_line_end;
    assign o_frame_end    = w_line_end && w_last_line;
    assign o_frame_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_pattern_gen                                                 |
// | Purpose  : VGA timing plus four frame-synchronous selectable test patterns |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int RGB_WIDTH  = c_RGB_WIDTH,
    parameter int H_DISPLAY  = c_H_DISPLAY,
    parameter int H_FP       = c_H_FP,
    parameter int H_SYNC     = c_H_SYNC,
    parameter int H_BP       = c_H_BP,
    parameter int V_DISPLAY  = c_V_DISPLAY,
    parameter int V_FP       = c_V_FP,
    parameter int V_SYNC     = c_V_SYNC,
    parameter int V_BP       = c_V_BP,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int GRID_SHIFT = c_GRID_SHIFT
) (
    input  logic                 pixel_clk,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    output logic [RGB_WIDTH-1:0] R,
    output logic [RGB_WIDTH-1:0] G,
    output logic [RGB_WIDTH-1:0] B,
    output logic                 HSYNC,
    output logic                 VSYNC,
    output logic                 DISPLAY,
    output logic                 frame_start
);

    localparam int c_H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int c_CW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_BAR_W   = H_DISPLAY / 8;
    localparam int c_PW      = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;

    logic [c_CW-1:0]      w_h_cnt;
    logic [c_VW-1:0]      w_v_cnt;
    logic                 w_hsync, w_vsync, w_visible;
    logic                 w_line_end, w_frame_end, w_origin;
    pattern_mode_t        r_mode_q;
    logic [7:0]           r_frame_cnt;
    logic [c_PW-1:0]      r_bar_pix;
    logic [2:0]           r_bar_idx;
    logic [2:0]           w_scroll_idx;
    logic                 w_grid_on;
    logic [RGB_WIDTH-1:0] w_ramp;
    logic [2:0]           w_bits;
    logic                 w_use_ramp;
    logic [RGB_WIDTH-1:0] w_r, w_g, w_b;
    logic                 w_unused_fcnt;

    vga_timing #(
        .H_DISPLAY (H_DISPLAY), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_DISPLAY (V_DISPLAY), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HSYNC_POL (HSYNC_POL), .VSYNC_POL (VSYNC_POL)
    ) u_timing (
        .clk            (pixel_clk),
        .rst_n          (reset_n),
        .o_h_cnt        (w_h_cnt),
        .o_v_cnt        (w_v_cnt),
        .o_hsync        (w_hsync),
        .o_vsync        (w_vsync),
        .o_visible      (w_visible),
        .o_line_end     (w_line_end),
        .o_frame_end    (w_frame_end),
        .o_frame_origin (w_origin)
    );

    // Mode and frame count move together at the frame wrap, so a new pattern never tears
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_q    <= PM_BARS;
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_mode_q    <= pattern_mode_t'(mode);
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    // Cleared on line wrap so the counters track h_cnt = 0 in the same cycle
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bar_pix <= '0;
            r_bar_idx <= '0;
        end else if (w_line_end) begin
            r_bar_pix <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_pix == c_PW'(c_BAR_W - 1)) begin
            r_bar_pix <= '0;
            r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
        end else begin
            r_bar_pix <= r_bar_pix + c_PW'(1);
        end
    end

    assign w_scroll_idx  = r_bar_idx + r_frame_cnt[5:3];
    assign w_unused_fcnt = ^{r_frame_cnt[7:6], r_frame_cnt[2:0]};
    assign w_grid_on     = (w_h_cnt[GRID_SHIFT-1:0] == '0)
                        || (w_v_cnt[GRID_SHIFT-1:0] == '0)
                        || (w_h_cnt == c_CW'(H_DISPLAY - 1))
                        || (w_v_cnt == c_VW'(V_DISPLAY - 1));

    generate
        if (c_CW >= RGB_WIDTH) begin : g_ramp_trunc
            assign w_ramp = w_h_cnt[c_CW-1 -: RGB_WIDTH];
        end else begin : g_ramp_pad
            assign w_ramp = {w_h_cnt, {(RGB_WIDTH - c_CW){1'b0}}};
        end
    endgenerate

    always_comb begin
        w_bits     = 3'b000;
        w_use_ramp = 1'b0;
        w_r        = '0;
        w_g        = '0;
        w_b        = '0;
        case (r_mode_q)
            PM_BARS:   w_bits     = bar_color(r_bar_idx);
            PM_GRID:   w_bits     = {3{w_grid_on}};
            PM_RAMP:   w_use_ramp = 1'b1;
            PM_SCROLL: w_bits     = bar_color(w_scroll_idx);
            default:   w_bits     = 3'b000;
        endcase
        if (w_visible) begin
            w_r = w_use_ramp ? w_ramp : {RGB_WIDTH{w_bits[2]}};
            w_g = w_use_ramp ? w_ramp : {RGB_WIDTH{w_bits[1]}};
            w_b = w_use_ramp ? w_ramp : {RGB_WIDTH{w_bits[0]}};
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            R           <= '0;
            G           <= '0;
            B           <= '0;
            HSYNC       <= ~HSYNC_POL;
            VSYNC       <= ~VSYNC_POL;
            DISPLAY     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            R           <= w_r;
            G           <= w_g;
            B           <= w_b;
            HSYNC       <= w_hsync;
            VSYNC       <= w_vsync;
            DISPLAY     <= w_visible;
            frame_start <= w_origin;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_pattern_gen                                              |
// | Purpose  : Directed self-checking bench on a reduced 20x9 raster           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vga_pattern_gen;

    localparam int RGBW = 8;
    localparam int HD = 16, HFP = 1, HS = 2, HBP = 1;
    localparam int VD = 6,  VFP = 1, VS = 1, VBP = 1;
    localparam int GS = 2;
    localparam int HT = HD + HFP + HS + HBP;   // 20, CW = 5 < RGBW so the ramp is LSB padded
    localparam int VT = VD + VFP + VS + VBP;   // 9
    localparam int FRAME = HT * VT;             // 180

    logic            pixel_clk = 1'b0;
    logic            reset_n   = 1'b0;
    logic [1:0]      mode      = 2'd0;
    logic [RGBW-1:0] R, G, B;
    logic            HSYNC, VSYNC, DISPLAY, frame_start;

    int         n_vec = 0;
    int         n_bad = 0;
    int         pix_n = -1;
    int         ex = 0, ey = 0, ef = 0;
    logic [1:0] eff_mode = 2'd0;
    logic [1:0] pend_mode = 2'd0;

    always #5 pixel_clk = ~pixel_clk;

    vga_pattern_gen #(
        .RGB_WIDTH (RGBW),
        .H_DISPLAY (HD), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_DISPLAY (VD), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
        .GRID_SHIFT (GS)
    ) dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .R           (R),
        .G           (G),
        .B           (B),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .DISPLAY     (DISPLAY),
        .frame_start (frame_start)
    );

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // {R,G,B,HSYNC,VSYNC,DISPLAY,frame_start} for pixel (x,y) of frame f in mode m
    function automatic logic [27:0] exp_out(input logic [1:0] m, input int x, input int y, input int f);
        logic        vis, hs, vs, fs, grid;
        logic [23:0] rgb;
        logic [7:0]  ramp;
        int          idx;
        vis  = (x < HD) && (y < VD);
        hs   = !((x >= HD + HFP) && (x < HD + HFP + HS));
        vs   = !((y >= VD + VFP) && (y < VD + VFP + VS));
        fs   = (x == 0) && (y == 0);
        idx  = (x / (HD / 8) > 7) ? 7 : x / (HD / 8);
        grid = (x % 4 == 0) || (y % 4 == 0) || (x == HD - 1) || (y == VD - 1);
        ramp = 8'(x * 8);
        rgb  = 24'h0;
        if (vis) begin
            case (m)
                2'd0: rgb = bar_rgb(idx);
                2'd1: rgb = grid ? 24'hFFFFFF : 24'h000000;
                2'd2: rgb = {ramp, ramp, ramp};
                default: rgb = bar_rgb((idx + (f / 8) % 8) % 8);
            endcase
        end
        return {rgb, hs, vs, vis, fs};
    endfunction

    task automatic step();
        logic [1:0] m_pre;
        m_pre = mode;
        @(posedge pixel_clk);
        #1;
        pix_n++;
        if (pix_n > 0 && pix_n % FRAME == 0) eff_mode = pend_mode;
        if (pix_n % FRAME == FRAME - 1) pend_mode = m_pre;
        ex = pix_n % HT;
        ey = (pix_n / HT) % VT;
        ef = (pix_n / FRAME) % 256;
    endtask

    task automatic goto(input int x, input int y);
        int budget;
        budget = 2 * FRAME;
        do begin
            step();
            budget--;
        end while (!(ex == x && ey == y) && budget > 0);
        if (!(ex == x && ey == y)) begin
            n_vec++; n_bad++;
            $display("FAIL goto: reached (%0d,%0d), required (%0d,%0d)", ex, ey, x, y);
        end
    endtask

    task automatic release_reset();
        @(negedge pixel_clk);
        reset_n   = 1'b1;
        pix_n     = -1;
        eff_mode  = 2'd0;
        pend_mode = 2'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        n_vec++;
        if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== {24'h0, 4'b1100}) begin
            n_bad++;
            $display("FAIL reset_state: got %h, required %h",
                     {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, {24'h0, 4'b1100});
        end
        release_reset();
    endtask

    task automatic test_first_pixel();
        step();
        n_vec++;
        if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== {24'hFFFFFF, 4'b1111}) begin
            n_bad++;
            $display("FAIL first_pixel: got %h, required %h",
                     {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, {24'hFFFFFF, 4'b1111});
        end
    endtask

    task automatic test_timing();
        int hs_low, de_cnt, vs_low;
        hs_low = 0; de_cnt = 1; vs_low = 0;
        while (pix_n < FRAME - 1) begin
            step();
            n_vec++;
            if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== exp_out(eff_mode, ex, ey, ef)) begin
                n_bad++;
                $display("FAIL timing_frame0 (%0d,%0d): got %h, required %h", ex, ey,
                         {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, exp_out(eff_mode, ex, ey, ef));
            end
            if (ey == 0 && !HSYNC) hs_low++;
            if (ey == 0 && DISPLAY) de_cnt++;
            if (!VSYNC) vs_low++;
        end
        n_vec++;
        if (hs_low != 2) begin n_bad++; $display("FAIL hsync_low_width: got %0d, required 2", hs_low); end
        n_vec++;
        if (de_cnt != 16) begin n_bad++; $display("FAIL display_per_line: got %0d, required 16", de_cnt); end
        n_vec++;
        if (vs_low != 20) begin n_bad++; $display("FAIL vsync_low_width: got %0d, required 20", vs_low); end
        step();
        n_vec++;
        if (frame_start !== 1'b1) begin
            n_bad++; $display("FAIL frame_period: got frame_start=%b at pixel %0d, required 1", frame_start, pix_n);
        end
    endtask

    task automatic test_bars();
        goto(2, 0);
        n_vec++;
        if ({R, G, B} !== 24'hFFFF00) begin n_bad++; $display("FAIL bar_yellow: got %h, required ffff00", {R, G, B}); end
        goto(12, 0);
        n_vec++;
        if ({R, G, B} !== 24'h0000FF) begin n_bad++; $display("FAIL bar_blue: got %h, required 0000ff", {R, G, B}); end
        goto(15, 0);
        n_vec++;
        if ({R, G, B, DISPLAY} !== {24'h0, 1'b1}) begin
            n_bad++; $display("FAIL bar_last_col: got %h, required %h", {R, G, B, DISPLAY}, {24'h0, 1'b1});
        end
        goto(16, 0);
        n_vec++;
        if ({R, G, B, DISPLAY} !== 25'h0) begin
            n_bad++; $display("FAIL bar_blank: got %h, required 0", {R, G, B, DISPLAY});
        end
    endtask

    task automatic test_mode_switch();
        goto(0, 2);
        mode = 2'd1;
        while (pix_n % FRAME != 0) begin
            step();
            n_vec++;
            if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== exp_out(eff_mode, ex, ey, ef)) begin
                n_bad++;
                $display("FAIL switch_frame (%0d,%0d): got %h, required %h", ex, ey,
                         {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, exp_out(eff_mode, ex, ey, ef));
            end
            if (ex == 2 && ey == 3 && {R, G, B} !== 24'hFFFF00) begin
                n_vec++; n_bad++;
                $display("FAIL switch_holds_bars: got %h, required ffff00", {R, G, B});
            end
        end
        goto(4, 1);
        n_vec++;
        if ({R, G, B} !== 24'hFFFFFF) begin n_bad++; $display("FAIL grid_4_1: got %h, required ffffff", {R, G, B}); end
        goto(5, 1);
        n_vec++;
        if ({R, G, B} !== 24'h000000) begin n_bad++; $display("FAIL grid_5_1: got %h, required 000000", {R, G, B}); end
        goto(6, 4);
        n_vec++;
        if ({R, G, B} !== 24'hFFFFFF) begin n_bad++; $display("FAIL grid_6_4: got %h, required ffffff", {R, G, B}); end
        goto(15, 5);
        n_vec++;
        if ({R, G, B} !== 24'hFFFFFF) begin n_bad++; $display("FAIL grid_15_5: got %h, required ffffff", {R, G, B}); end
    endtask

    task automatic test_ramp();
        mode = 2'd2;
        goto(1, 0);
        n_vec++;
        if ({R, G, B} !== 24'h080808) begin n_bad++; $display("FAIL ramp_x1: got %h, required 080808", {R, G, B}); end
        goto(13, 3);
        n_vec++;
        if ({R, G, B} !== 24'h686868) begin n_bad++; $display("FAIL ramp_x13: got %h, required 686868", {R, G, B}); end
    endtask

    task automatic test_scroll();
        logic [23:0] want;
        mode = 2'd3;
        while (pix_n < 258 * FRAME) begin
            step();
            n_vec++;
            if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== exp_out(eff_mode, ex, ey, ef)) begin
                n_bad++;
                $display("FAIL scroll f%0d (%0d,%0d): got %h, required %h", ef, ex, ey,
                         {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, exp_out(eff_mode, ex, ey, ef));
            end
            if (ex == 0 && ey == 0 && pix_n >= 5 * FRAME && (ef == 7 || ef == 8 || ef == 16 || ef == 255 || ef == 0)) begin
                case (ef)
                    7:       want = 24'hFFFFFF;
                    8:       want = 24'hFFFF00;
                    16:      want = 24'h00FFFF;
                    255:     want = 24'h000000;
                    default: want = 24'hFFFFFF;
                endcase
                n_vec++;
                if ({R, G, B} !== want) begin
                    n_bad++; $display("FAIL scroll_origin f%0d: got %h, required %h", ef, {R, G, B}, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        goto(12, 3);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== {24'h0, 4'b1100}) begin
            n_bad++;
            $display("FAIL async_reset: got %h, required %h",
                     {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, {24'h0, 4'b1100});
        end
        @(posedge pixel_clk);
        #1;
        n_vec++;
        if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== {24'h0, 4'b1100}) begin
            n_bad++;
            $display("FAIL reset_hold: got %h, required %h",
                     {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, {24'h0, 4'b1100});
        end
        release_reset();
        step();
        n_vec++;
        if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== {24'hFFFFFF, 4'b1111}) begin
            n_bad++;
            $display("FAIL restart_origin: got %h, required %h",
                     {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, {24'hFFFFFF, 4'b1111});
        end
        repeat (2 * FRAME) begin
            step();
            n_vec++;
            if ({R, G, B, HSYNC, VSYNC, DISPLAY, frame_start} !== exp_out(eff_mode, ex, ey, ef)) begin
                n_bad++;
                $display("FAIL restart_frame f%0d (%0d,%0d): got %h, required %h", ef, ex, ey,
                         {R, G, B, HSYNC, VSYNC, DISPLAY, frame_start}, exp_out(eff_mode, ex, ey, ef));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_pixel();
        test_timing();
        test_bars();
        test_mode_switch();
        test_ramp();
        test_scroll();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
